// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and default geometry for the set-associative line store
package cache_pkg;

    localparam int CACHE_RD_PORTS = 2;
    localparam int CACHE_WAYS     = 4;
    localparam int CACHE_SETS     = 8;
    localparam int CACHE_DATA_BITS = 64;
    localparam int CACHE_TAG_BITS = 26;

    localparam int CACHE_IDX_BITS = $clog2(CACHE_SETS);
    localparam int CACHE_WAY_BITS = $clog2(CACHE_WAYS);

    typedef logic [CACHE_IDX_BITS-1:0]  cache_idx_t;
    typedef logic [CACHE_TAG_BITS-1:0]  cache_tag_t;
    typedef logic [CACHE_WAY_BITS-1:0]  cache_way_t;

    typedef struct packed {
        logic                       valid;
        cache_tag_t                 tag;
        logic [CACHE_DATA_BITS-1:0] data;
    } cache_line_t;

endpackage

// File: rtl/lru_age_set.sv
// rtl/lru_age_set.sv - true-LRU age vector of one set with ordered multi-touch update
module lru_age_set
    import cache_pkg::*;
#(
    parameter int NUM_WAYS  = CACHE_WAYS,
    parameter int NUM_TOUCH = CACHE_RD_PORTS + 1,
    localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_TOUCH-1:0]               i_touch_en,
    input  logic [NUM_TOUCH-1:0][WAY_BITS-1:0] i_touch_way,
    output logic [WAY_BITS-1:0]                o_lru_way
);

    // Age 0 is most recently used, NUM_WAYS-1 least; the vector is always a permutation.
    logic [NUM_WAYS-1:0][WAY_BITS-1:0] r_age;
    logic [NUM_WAYS-1:0][WAY_BITS-1:0] w_age_next;
    logic [WAY_BITS-1:0]               w_pivot;

    // Apply touches in port order, each one seeing the ages left by the previous.
    always_comb begin
        w_age_next = r_age;
        w_pivot    = '0;
        for (int t = 0; t < NUM_TOUCH; t++) begin
            if (i_touch_en[t]) begin
                w_pivot = w_age_next[i_touch_way[t]];
                for (int k = 0; k < NUM_WAYS; k++) begin
                    if (w_age_next[k] < w_pivot) begin
                        w_age_next[k] = w_age_next[k] + WAY_BITS'(1);
                    end
                end
                w_age_next[i_touch_way[t]] = '0;
            end
        end
    end

    // Age register; reset leaves way w with age w.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                r_age[w] <= WAY_BITS'(w);
            end
        end else begin
            r_age <= w_age_next;
        end
    end

    // The replacement victim is the way currently holding the oldest age.
    always_comb begin
        o_lru_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_age[w] == WAY_BITS'(NUM_WAYS - 1)) begin
                o_lru_way = WAY_BITS'(w);
            end
        end
    end

endmodule

// File: rtl/assoc_cachemem.sv
// rtl/assoc_cachemem.sv - N-way set-associative line store with LRU fill, eviction and invalidate
module assoc_cachemem
    import cache_pkg::*;
#(
    parameter int NUM_RD_PORTS = CACHE_RD_PORTS,
    parameter int NUM_WAYS     = CACHE_WAYS,
    parameter int NUM_SETS     = CACHE_SETS,
    parameter int DATA_BITS    = CACHE_DATA_BITS,
    parameter int TAG_BITS     = CACHE_TAG_BITS,
    localparam int IDX_BITS    = $clog2(NUM_SETS),
    localparam int WAY_BITS    = $clog2(NUM_WAYS)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUM_RD_PORTS-1:0]                rd_en,
    input  logic [NUM_RD_PORTS-1:0][IDX_BITS-1:0]  rd_idx,
    input  logic [NUM_RD_PORTS-1:0][TAG_BITS-1:0]  rd_tag,
    output logic [NUM_RD_PORTS-1:0]                rd_hit,
    output logic [NUM_RD_PORTS-1:0][WAY_BITS-1:0]  rd_way,
    output logic [NUM_RD_PORTS-1:0][DATA_BITS-1:0] rd_data,
    input  logic                                   wr_en,
    input  logic [IDX_BITS-1:0]                    wr_idx,
    input  logic [TAG_BITS-1:0]                    wr_tag,
    input  logic [DATA_BITS-1:0]                   wr_data,
    output logic                                   evict_valid,
    output logic [TAG_BITS-1:0]                    evict_tag,
    output logic [DATA_BITS-1:0]                   evict_data,
    input  logic                                   inv_en,
    input  logic [IDX_BITS-1:0]                    inv_idx,
    input  logic [TAG_BITS-1:0]                    inv_tag
);

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] r_valid;
    logic [TAG_BITS-1:0]               r_tag  [NUM_SETS][NUM_WAYS];
    logic [DATA_BITS-1:0]              r_data [NUM_SETS][NUM_WAYS];

    logic [WAY_BITS-1:0] w_lru_way [NUM_SETS];

    logic                w_ref_found;
    logic [WAY_BITS-1:0] w_ref_way;
    logic                w_free_found;
    logic [WAY_BITS-1:0] w_free_way;
    logic [WAY_BITS-1:0] w_victim_way;
    logic [WAY_BITS-1:0] w_fill_way;
    logic                w_do_evict;
    logic                w_inv_found;
    logic [WAY_BITS-1:0] w_inv_way;

    // Zero-latency lookup on every port against the pre-edge contents.
    always_comb begin
        rd_hit  = '0;
        rd_way  = '0;
        rd_data = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (!rd_hit[p] && r_valid[rd_idx[p]][w] &&
                    (r_tag[rd_idx[p]][w] == rd_tag[p])) begin
                    rd_hit[p]  = 1'b1;
                    rd_way[p]  = WAY_BITS'(w);
                    rd_data[p] = r_data[rd_idx[p]][w];
                end
            end
        end
    end

    // Fill way choice: refresh a matching line, else lowest free way, else the LRU victim.
    always_comb begin
        w_ref_found  = 1'b0;
        w_ref_way    = '0;
        w_free_found = 1'b0;
        w_free_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!w_ref_found && r_valid[wr_idx][w] && (r_tag[wr_idx][w] == wr_tag)) begin
                w_ref_found = 1'b1;
                w_ref_way   = WAY_BITS'(w);
            end
            if (!w_free_found && !r_valid[wr_idx][w]) begin
                w_free_found = 1'b1;
                w_free_way   = WAY_BITS'(w);
            end
        end
        w_victim_way = w_lru_way[wr_idx];
        if (w_ref_found) begin
            w_fill_way = w_ref_way;
        end else if (w_free_found) begin
            w_fill_way = w_free_way;
        end else begin
            w_fill_way = w_victim_way;
        end
        w_do_evict = wr_en && !w_ref_found && !w_free_found;
    end

    // Eviction report is only non-zero when a valid line with another tag is displaced.
    always_comb begin
        evict_valid = w_do_evict;
        evict_tag   = '0;
        evict_data  = '0;
        if (w_do_evict) begin
            evict_tag  = r_tag[wr_idx][w_victim_way];
            evict_data = r_data[wr_idx][w_victim_way];
        end
    end

    // Locate the valid line an invalidate targets; a miss leaves the set alone.
    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!w_inv_found && r_valid[inv_idx][w] && (r_tag[inv_idx][w] == inv_tag)) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_BITS'(w);
            end
        end
    end

    // Line storage; the fill is written after the invalidate so a same-line fill ends valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_tag[s][w]  <= '0;
                    r_data[s][w] <= '0;
                end
            end
        end else begin
            if (inv_en && w_inv_found) begin
                r_valid[inv_idx][w_inv_way] <= 1'b0;
            end
            if (wr_en) begin
                r_valid[wr_idx][w_fill_way] <= 1'b1;
                r_tag[wr_idx][w_fill_way]   <= wr_tag;
                r_data[wr_idx][w_fill_way]  <= wr_data;
            end
        end
    end

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        logic [NUM_RD_PORTS:0]               w_touch_en;
        logic [NUM_RD_PORTS:0][WAY_BITS-1:0] w_touch_way;

        // Read hits touch first in port order, the fill touches last so it ends MRU.
        always_comb begin
            w_touch_en  = '0;
            w_touch_way = '0;
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                w_touch_en[p]  = rd_en[p] && rd_hit[p] && (rd_idx[p] == IDX_BITS'(s));
                w_touch_way[p] = rd_way[p];
            end
            w_touch_en[NUM_RD_PORTS]  = wr_en && (wr_idx == IDX_BITS'(s));
            w_touch_way[NUM_RD_PORTS] = w_fill_way;
        end

        lru_age_set #(
            .NUM_WAYS  (NUM_WAYS),
            .NUM_TOUCH (NUM_RD_PORTS + 1)
        ) u_lru (
            .clock       (clock),
            .reset       (reset),
            .i_touch_en  (w_touch_en),
            .i_touch_way (w_touch_way),
            .o_lru_way   (w_lru_way[s])
        );
    end

endmodule

// File: tb/tb_assoc_cachemem.sv
// tb/tb_assoc_cachemem.sv - scoreboard bench for assoc_cachemem against a recency-list model
module tb_assoc_cachemem;

    localparam int NP = 2;
    localparam int NW = 4;
    localparam int NS = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NP-1:0]        rd_en;
    logic [NP-1:0][2:0]   rd_idx;
    logic [NP-1:0][25:0]  rd_tag;
    logic [NP-1:0]        rd_hit;
    logic [NP-1:0][1:0]   rd_way;
    logic [NP-1:0][63:0]  rd_data;
    logic                 wr_en;
    logic [2:0]           wr_idx;
    logic [25:0]          wr_tag;
    logic [63:0]          wr_data;
    logic                 evict_valid;
    logic [25:0]          evict_tag;
    logic [63:0]          evict_data;
    logic                 inv_en;
    logic [2:0]           inv_idx;
    logic [25:0]          inv_tag;

    assoc_cachemem dut (
        .clock       (clock),
        .reset       (reset),
        .rd_en       (rd_en),
        .rd_idx      (rd_idx),
        .rd_tag      (rd_tag),
        .rd_hit      (rd_hit),
        .rd_way      (rd_way),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_tag      (wr_tag),
        .wr_data     (wr_data),
        .evict_valid (evict_valid),
        .evict_tag   (evict_tag),
        .evict_data  (evict_data),
        .inv_en      (inv_en),
        .inv_idx     (inv_idx),
        .inv_tag     (inv_tag)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NP-1:0]       hit;
        logic [NP-1:0][1:0]  way;
        logic [NP-1:0][63:0] data;
        logic                ev;
        logic [25:0]         etag;
        logic [63:0]         edata;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: contents plus a recency list per set (position 0 = most recent).
    logic        m_valid [NS][NW];
    logic [25:0] m_tag   [NS][NW];
    logic [63:0] m_data  [NS][NW];
    int          m_ord   [NS][NW];

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_data[s][w]  = '0;
                m_ord[s][w]   = w;
            end
        end
    endfunction

    function automatic int find(input logic [2:0] s, input logic [25:0] t);
        for (int w = 0; w < NW; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        end
        return -1;
    endfunction

    function automatic void touch(input logic [2:0] s, input int way);
        int pos = 0;
        for (int i = 0; i < NW; i++) if (m_ord[s][i] == way) pos = i;
        for (int i = pos; i > 0; i--) m_ord[s][i] = m_ord[s][i-1];
        m_ord[s][0] = way;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare the DUT's outputs mid-cycle with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int p = 0; p < NP; p++) begin
                    chk($sformatf("rd_hit[%0d]", p),  64'(rd_hit[p]),  64'(e.hit[p]));
                    chk($sformatf("rd_way[%0d]", p),  64'(rd_way[p]),  64'(e.way[p]));
                    chk($sformatf("rd_data[%0d]", p), rd_data[p],      e.data[p]);
                end
                chk("evict_valid", 64'(evict_valid), 64'(e.ev));
                chk("evict_tag",   64'(evict_tag),   64'(e.etag));
                chk("evict_data",  evict_data,       e.edata);
            end
        end
    end

    // One cycle: predict from the model, queue it, then advance the model across the edge.
    task automatic step();
        exp_t        e;
        int          rw [NP];
        int          ref_w, free_w, fw, iw;
        e = '0;
        for (int p = 0; p < NP; p++) begin
            rw[p] = find(rd_idx[p], rd_tag[p]);
            if (rw[p] >= 0) begin
                e.hit[p]  = 1'b1;
                e.way[p]  = 2'(rw[p]);
                e.data[p] = m_data[rd_idx[p]][rw[p]];
            end
        end
        ref_w  = find(wr_idx, wr_tag);
        free_w = -1;
        for (int w = NW - 1; w >= 0; w--) if (!m_valid[wr_idx][w]) free_w = w;
        if (ref_w >= 0) fw = ref_w;
        else if (free_w >= 0) fw = free_w;
        else begin
            fw = m_ord[wr_idx][NW-1];
            if (wr_en) begin
                e.ev    = 1'b1;
                e.etag  = m_tag[wr_idx][fw];
                e.edata = m_data[wr_idx][fw];
            end
        end
        iw = inv_en ? find(inv_idx, inv_tag) : -1;
        sb.push_back(e);
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            for (int p = 0; p < NP; p++) if (rd_en[p] && rw[p] >= 0) touch(rd_idx[p], rw[p]);
            if (wr_en) touch(wr_idx, fw);
            if (iw >= 0) m_valid[inv_idx][iw] = 1'b0;
            if (wr_en) begin
                m_valid[wr_idx][fw] = 1'b1;
                m_tag[wr_idx][fw]   = wr_tag;
                m_data[wr_idx][fw]  = wr_data;
            end
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; rd_en = '0; rd_idx = '0; rd_tag = '0;
        wr_en = 1'b0; wr_idx = '0; wr_tag = '0; wr_data = '0;
        inv_en = 1'b0; inv_idx = '0; inv_tag = '0;
    endtask

    task automatic fill(input logic [2:0] s, input logic [25:0] t, input logic [63:0] d);
        idle(); wr_en = 1'b1; wr_idx = s; wr_tag = t; wr_data = d; step();
    endtask

    task automatic read2(input logic [2:0] s0, input logic [25:0] t0,
                         input logic [2:0] s1, input logic [25:0] t1);
        idle(); rd_en = 2'b11;
        rd_idx[0] = s0; rd_tag[0] = t0; rd_idx[1] = s1; rd_tag[1] = t1;
        step();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        // Reset state seen while still in reset, then first lookup after release.
        rd_en = 2'b11; rd_idx[0] = 3'd3; rd_tag[0] = 26'h5; step();
        read2(3'd3, 26'h5, 3'd0, 26'h0);

        // Set 2: four fills land in ways 0..3, then hit/evict/refresh.
        fill(3'd2, 26'hA, 64'hAAAA);
        fill(3'd2, 26'hB, 64'hBBBB);
        fill(3'd2, 26'hC, 64'hCCCC);
        fill(3'd2, 26'hD, 64'hDDDD);
        read2(3'd2, 26'hB, 3'd2, 26'hD);
        read2(3'd2, 26'hB, 3'd7, 26'h1);
        fill(3'd2, 26'hE, 64'hEEEE);
        read2(3'd2, 26'hA, 3'd2, 26'hE);
        fill(3'd2, 26'hC, 64'h1234);
        read2(3'd2, 26'hC, 3'd2, 26'hD);

        // Set 5: two read touches and a fill in one cycle, then expose the ordering.
        fill(3'd5, 26'h10, 64'h10);
        fill(3'd5, 26'h11, 64'h11);
        fill(3'd5, 26'h12, 64'h12);
        fill(3'd5, 26'h13, 64'h13);
        idle(); rd_en = 2'b11; rd_idx[0] = 3'd5; rd_tag[0] = 26'h11;
        rd_idx[1] = 3'd5; rd_tag[1] = 26'h13;
        wr_en = 1'b1; wr_idx = 3'd5; wr_tag = 26'h20; wr_data = 64'h20; step();
        fill(3'd5, 26'h21, 64'h21);
        fill(3'd5, 26'h22, 64'h22);
        fill(3'd5, 26'h23, 64'h23);
        fill(3'd5, 26'h24, 64'h24);

        // Set 4: fill+invalidate same line, invalidate alone, invalid-first refill.
        fill(3'd4, 26'h6, 64'h6);
        fill(3'd4, 26'h7, 64'h7);
        idle(); wr_en = 1'b1; wr_idx = 3'd4; wr_tag = 26'h7; wr_data = 64'h77;
        inv_en = 1'b1; inv_idx = 3'd4; inv_tag = 26'h7; step();
        read2(3'd4, 26'h7, 3'd4, 26'h6);
        idle(); inv_en = 1'b1; inv_idx = 3'd4; inv_tag = 26'h6; step();
        read2(3'd4, 26'h6, 3'd4, 26'h7);
        fill(3'd4, 26'h8, 64'h8);
        read2(3'd4, 26'h8, 3'd4, 26'h7);

        // Reset in the middle of activity wipes everything, including that cycle's fill.
        idle(); reset = 1'b1; wr_en = 1'b1; wr_idx = 3'd2; wr_tag = 26'hF; wr_data = 64'hF;
        rd_en = 2'b01; rd_idx[0] = 3'd2; rd_tag[0] = 26'hE; step();
        read2(3'd2, 26'hF, 3'd2, 26'hE);

        // Randomised traffic over a narrow index/tag space to force hits, misses and evictions.
        for (int i = 0; i < 3000; i++) begin
            idle();
            reset = ($urandom_range(0, 499) == 0);
            for (int p = 0; p < NP; p++) begin
                rd_en[p]  = $urandom_range(0, 3) != 0;
                rd_idx[p] = 3'($urandom_range(0, 3));
                rd_tag[p] = 26'($urandom_range(0, 9));
            end
            wr_en   = $urandom_range(0, 1) == 1;
            wr_idx  = 3'($urandom_range(0, 3));
            wr_tag  = 26'($urandom_range(0, 9));
            wr_data = {$urandom, $urandom};
            inv_en  = $urandom_range(0, 3) == 0;
            inv_idx = 3'($urandom_range(0, 3));
            inv_tag = 26'($urandom_range(0, 9));
            step();
        end

        idle();
        repeat (2) @(negedge clock);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
